uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial UART receiver, 8N1, LSB first, idle-high line. It is the downstream counterpart of uart_tx: it consumes the serial stream produced on PIN_1 and presents each received byte with a one-cycle valid strobe. Bit timing uses the same BAUD_MULT clocks-per-bit scheme as uart_tx: 139 at 16 MHz for ~115200 baud, 3 in simulation. In loopback benches it connects directly to uart_tx o_tx_data.

Parameters:
BAUD_MULT, 139, clock cycles per bit; must be >= 3
HALF_BIT, BAUD_MULT/2 (integer division), cycles from start-bit detect to start-bit validation sample

Ports:
i_uart_clk  input  1  system clock (16 MHz on board)
i_reset  input  1  synchronous, active-high reset
i_rx_data  input  1  asynchronous serial line, idle high
o_byte_out  output  8  last correctly framed byte; holds until the next good frame
o_data_valid  output  1  one-cycle pulse when o_byte_out updates
o_rx_active  output  1  high while the FSM is outside IDLE
o_frame_err  output  1  one-cycle pulse when the stop bit is sampled low

Behaviour:
- One clock: i_uart_clk. Reset is synchronous and active-high on i_reset.
- Reset values: o_byte_out=0, o_data_valid=0, o_rx_active=0, o_frame_err=0, FSM=IDLE, counters=0. Both synchronizer flops reset to 1 (idle).
- Synchronizer: two flops on i_rx_data feed rx_s. All FSM decisions use rx_s only.
- Bit counter: width $clog2(BAUD_MULT). It resets to 0 on every state entry and after every sample.
- States:
  - IDLE: if rx_s==0, go to START with counter=0.
  - START: increment counter. When counter==HALF_BIT-1, sample rx_s. A 0 goes to DATA (counter=0, bit_idx=0). A 1 is a glitch: return to IDLE with no outputs.
  - DATA: when counter==BAUD_MULT-1, sample rx_s into shift_reg[7] and shift right (LSB first), then increment bit_idx. After the sample with bit_idx==7, go to STOP.
  - STOP: when counter==BAUD_MULT-1, sample rx_s.
    - 1: register o_byte_out<=shift_reg, pulse o_data_valid for 1 cycle, go to IDLE.
    - 0: pulse o_frame_err for 1 cycle, leave o_byte_out unchanged, go to BREAK_WAIT.
  - BREAK_WAIT: stay until rx_s==1, then go to IDLE. This prevents a held-low line (break) from retriggering frames.
- Latency: let edge E0 be the first clock edge that captures i_rx_data low. The stop sample is taken at edge E0 + 2 + HALF_BIT + 9*BAUD_MULT. o_data_valid / o_frame_err are high for exactly the cycle after that edge.
- o_rx_active is registered and high in START, DATA, STOP and BREAK_WAIT.
- Back-to-back frames: a start bit immediately after the stop bit is accepted. IDLE is re-entered at mid-stop, so up to half a bit of slack exists.
- o_data_valid and o_frame_err are never high in the same cycle.
- Reset mid-frame: abort immediately and apply reset values. The partial byte is discarded and no pulse is emitted.
- Arithmetic: compare counter against width-matched constants. bit_idx is 3 bits and must not wrap silently past 7 (the transition to STOP happens at 7).

Decomposition:
- Shared package uart_pkg:
  - state encodings (IDLE, START, DATA, STOP, BREAK_WAIT)
  - BAUD_MULT_BOARD=139 and BAUD_MULT_SIM=3
  - DATA_BITS=8
- uart_tx should migrate to the same package.
- One sub-module: uart_sync_2ff, a 2-flop synchronizer with parameterised reset value (1 here). It is reused for future async inputs.

Test Plan:
- BAUD_MULT=8, drive 0x48 ('H') as 8N1 → o_byte_out=0x48 and a single o_data_valid pulse at E0+2+4+72. o_frame_err stays 0 throughout.
- Loopback with uart_tx (BAUD_MULT=3), sending "Hello World!\n" → 13 valid pulses, bytes received in transmit order, no frame errors.
- Line low for 2 cycles, then high (BAUD_MULT=8) → START aborts to IDLE. No valid or error pulse; o_rx_active drops after HALF_BIT+2 cycles.
- Frame 0x55 with stop bit forced low, line held low for 3 further bit times, then high, then a clean 0xA3 → one o_frame_err pulse and o_byte_out unchanged. The FSM stays in BREAK_WAIT until the line goes high, then receives 0xA3 normally.
- Two back-to-back frames 0x00 and 0xFF with no idle gap → two valid pulses, spaced exactly 10*BAUD_MULT cycles apart.
- Assert i_reset during bit 4 of a frame, release, then send 0x3C → all outputs 0 on the cycle after reset. The aborted frame emits no pulse; 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encodings, bit-timing presets and frame width.
// Intended to be imported by both uart_rx and uart_tx.
package uart_pkg;

  localparam int BAUD_MULT_BOARD = 139;  // 16 MHz / 139 ~= 115200 baud
  localparam int BAUD_MULT_SIM   = 3;
  localparam int DATA_BITS       = 8;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_DATA       = 3'd2,
    ST_STOP       = 3'd3,
    ST_BREAK_WAIT = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset value is a parameter.
// Latency: 2 cycles. No backpressure.
module uart_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, idle-high line; emits each good byte with a one-cycle valid strobe.
// Stop bit sampled 2 + BAUD_MULT/2 + 9*BAUD_MULT cycles after the start edge; no backpressure.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_MULT = BAUD_MULT_BOARD
) (
  input  logic                 i_uart_clk,
  input  logic                 i_reset,
  input  logic                 i_rx_data,
  output logic [DATA_BITS-1:0] o_byte_out,
  output logic                 o_data_valid,
  output logic                 o_rx_active,
  output logic                 o_frame_err
);

  localparam int HALF_BIT = BAUD_MULT / 2;
  localparam int CW       = $clog2(BAUD_MULT);

  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_MULT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

  logic rx_s;

  uart_sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk_i(i_uart_clk),
    .rst_i(i_reset),
    .d_i  (i_rx_data),
    .q_o  (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 active_q, active_d;

  always_ff @(posedge i_uart_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      active_q  <= active_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end

      ST_START: begin
        // A start bit that is gone by mid-bit was a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == IDX_LAST) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_BREAK_WAIT;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_BREAK_WAIT: begin
        // A held-low line must return high before another start edge counts.
        if (rx_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign active_d = (state_d != ST_IDLE);

  assign o_byte_out   = byte_q;
  assign o_data_valid = valid_q;
  assign o_frame_err  = err_q;
  assign o_rx_active  = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BAUD_MULT=8: vector table of frames plus glitch, break,
// back-to-back, text stream and mid-frame reset sequences.
module tb_uart_rx;

  localparam int B   = 8;
  localparam int HB  = B / 2;
  localparam int LAT = 1 + 2 + HB + 9 * B;  // drive negedge -> negedge that sees o_data_valid

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] bo;
  logic       dv;
  logic       act;
  logic       fe;

  uart_rx #(.BAUD_MULT(B)) dut (
    .i_uart_clk  (clk),
    .i_reset     (rst),
    .i_rx_data   (rxd),
    .o_byte_out  (bo),
    .o_data_valid(dv),
    .o_rx_active (act),
    .o_frame_err (fe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         valid_cnt = 0;
  int         err_cnt   = 0;
  int         both_cnt  = 0;
  logic [7:0] rx_bytes[$];
  int         rx_cycs[$];

  always @(negedge clk) begin
    if (dv) begin
      valid_cnt++;
      rx_bytes.push_back(bo);
      rx_cycs.push_back(cyc);
    end
    if (fe) err_cnt++;
    if (dv && fe) both_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  int t0;

  task automatic hold(input logic b, input int n);
    repeat (n) begin
      @(negedge clk);
      rxd = b;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(negedge clk);
    t0  = cyc;
    rxd = 1'b0;
    repeat (B - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) hold(d[i], B);
    hold(stop, B);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int         v0, e0, base;
    logic [7:0] prev;
    string      msg;

    vecs[0] = '{8'h48, 1'b1, 1, 0, 8'h48};
    vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[3] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[4] = '{8'h55, 1'b0, 0, 1, 8'hA5};
    vecs[5] = '{8'h5A, 1'b1, 1, 0, 8'h5A};
    vecs[6] = '{8'h01, 1'b1, 1, 0, 8'h01};
    vecs[7] = '{8'h80, 1'b1, 1, 0, 8'h80};

    repeat (3) @(negedge clk);
    check("reset byte_out", bo, 0);
    check("reset data_valid", dv, 0);
    check("reset rx_active", act, 0);
    check("reset frame_err", fe, 0);
    rst = 1'b0;
    hold(1'b1, 4);

    for (int k = 0; k < 8; k++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      send_frame(vecs[k].data, vecs[k].stop);
      hold(1'b1, 2 * B);
      check($sformatf("vec%0d valid count", k), valid_cnt - v0, vecs[k].exp_valid);
      check($sformatf("vec%0d err count", k), err_cnt - e0, vecs[k].exp_err);
      check($sformatf("vec%0d byte_out", k), bo, vecs[k].exp_byte);
      check($sformatf("vec%0d rx_active idle", k), act, 0);
      if (vecs[k].exp_valid == 1)
        check($sformatf("vec%0d latency", k), rx_cycs[rx_cycs.size() - 1] - t0, LAT);
    end

    // Two-cycle low glitch: START aborts at the half-bit sample.
    v0 = valid_cnt;
    e0 = err_cnt;
    @(negedge clk);
    t0  = cyc;
    rxd = 1'b0;
    @(negedge clk);
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      rxd = 1'b1;
      check($sformatf("glitch rx_active k%0d", k), act, (k >= 3 && k <= 6) ? 1 : 0);
    end
    hold(1'b1, 2 * B);
    check("glitch no valid", valid_cnt - v0, 0);
    check("glitch no err", err_cnt - e0, 0);

    // Bad stop bit followed by a held-low break, then a clean frame.
    v0   = valid_cnt;
    e0   = err_cnt;
    prev = bo;
    send_frame(8'h55, 1'b0);
    hold(1'b0, 3 * B);
    check("break err pulse", err_cnt - e0, 1);
    check("break byte held", bo, prev);
    check("break rx_active", act, 1);
    check("break no valid", valid_cnt - v0, 0);
    hold(1'b1, B);
    check("break released", act, 0);
    send_frame(8'hA3, 1'b1);
    hold(1'b1, 2 * B);
    check("after break valid", valid_cnt - v0, 1);
    check("after break byte", bo, 8'hA3);
    check("after break err", err_cnt - e0, 1);

    // Back-to-back frames with no idle gap.
    v0 = valid_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    hold(1'b1, 2 * B);
    check("b2b valid count", valid_cnt - v0, 2);
    if (valid_cnt - v0 == 2) begin
      check("b2b byte0", rx_bytes[v0], 8'h00);
      check("b2b byte1", rx_bytes[v0 + 1], 8'hFF);
      check("b2b spacing", rx_cycs[v0 + 1] - rx_cycs[v0], 10 * B);
    end

    // Text stream, back to back.
    msg  = "Hello World!\n";
    base = valid_cnt;
    e0   = err_cnt;
    for (int i = 0; i < msg.len(); i++) send_frame(msg[i], 1'b1);
    hold(1'b1, 2 * B);
    check("text valid count", valid_cnt - base, msg.len());
    check("text no err", err_cnt - e0, 0);
    if (valid_cnt - base == msg.len())
      for (int i = 0; i < msg.len(); i++)
        check($sformatf("text char%0d", i), rx_bytes[base + i], msg[i]);

    // Reset during data bit 4.
    v0 = valid_cnt;
    e0 = err_cnt;
    @(negedge clk);
    rxd = 1'b0;
    repeat (B - 1) @(negedge clk);
    for (int i = 0; i < 4; i++) hold(1'b1, B);
    hold(1'b0, B / 2);
    @(negedge clk);
    rst = 1'b1;
    rxd = 1'b1;
    @(negedge clk);
    check("midreset byte_out", bo, 0);
    check("midreset data_valid", dv, 0);
    check("midreset rx_active", act, 0);
    check("midreset frame_err", fe, 0);
    rst = 1'b0;
    hold(1'b1, 2 * B);
    check("midreset no pulse", (valid_cnt - v0) + (err_cnt - e0), 0);
    send_frame(8'h3C, 1'b1);
    hold(1'b1, 2 * B);
    check("post-reset valid", valid_cnt - v0, 1);
    check("post-reset byte", bo, 8'h3C);
    check("post-reset latency", rx_cycs[rx_cycs.size() - 1] - t0, LAT);

    check("valid and err never together", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
